// File: rtl/vga_fb_pkg.sv
// Shared constants and types for the VGA framebuffer arbiter slice.
package vga_fb_pkg;

    // 640x480, 24-bit RGB framebuffer.
    localparam int DATA_W          = 24;
    localparam int ADDR_W          = 19;
    localparam int VGA_FRAME_WORDS = 640 * 480;

    // Scanout prefetch state.
    typedef enum logic [1:0] {
        ST_FLUSH = 2'd0,
        ST_RUN   = 2'd1,
        ST_DONE  = 2'd2
    } fb_state_e;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } pixel_t;

endpackage

// File: rtl/vga_pix_fifo.sv
// Show-ahead pixel FIFO with level output and synchronous clear.
// When empty, head holds the last word popped.
module vga_pix_fifo
    import vga_fb_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int LVL_W = IDX_W + 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [IDX_W-1:0] wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [WIDTH-1:0] last_q, last_d;
    logic             push_ok, pop_ok;

    // Pointer, level and last-popped bookkeeping; clear wins over push/pop.
    always_comb begin
        pop_ok   = pop && (level_q != '0);
        push_ok  = push && (level_q != FULL_LVL);
        wr_idx_d = wr_idx_q;
        rd_idx_d = rd_idx_q;
        level_d  = level_q;
        last_d   = last_q;
        if (clr) begin
            wr_idx_d = '0;
            rd_idx_d = '0;
            level_d  = '0;
        end else begin
            if (push_ok) begin
                wr_idx_d = wr_idx_q + 1'b1;
            end
            if (pop_ok) begin
                rd_idx_d = rd_idx_q + 1'b1;
                last_d   = mem_q[rd_idx_q];
            end
            case ({push_ok, pop_ok})
                2'b10:   level_d = level_q + 1'b1;
                2'b01:   level_d = level_q - 1'b1;
                default: level_d = level_q;
            endcase
        end
    end

    // Control registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_idx_q <= '0;
            rd_idx_q <= '0;
            level_q  <= '0;
            last_q   <= '0;
        end else begin
            wr_idx_q <= wr_idx_d;
            rd_idx_q <= rd_idx_d;
            level_q  <= level_d;
            last_q   <= last_d;
        end
    end

    // Storage array; contents are masked by last_q while empty, so no reset.
    always_ff @(posedge clk) begin
        if (push_ok && !clr) begin
            mem_q[wr_idx_q] <= push_data;
        end
    end

    // Show-ahead head: next word when non-empty, last popped word otherwise.
    always_comb begin
        empty = (level_q == '0);
        level = level_q;
        head  = empty ? last_q : mem_q[rd_idx_q];
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Shares a single-port framebuffer between raster-order scanout prefetch
// and one pixel writer. Scanout reads fill a show-ahead FIFO drained by the
// colour stage; the writer takes every slot scanout does not claim.
//
// Writer handshake: a write transfers in any cycle where wr_valid and
// wr_ready are both high. wr_ready is combinational and may depend on
// wr_valid; the writer holds wr_addr/wr_data stable until it transfers.
module vga_fb_arbiter
    import vga_fb_pkg::*;
#(
    parameter int FRAME_WORDS = VGA_FRAME_WORDS,
    parameter int FIFO_DEPTH  = 16,
    parameter int LOW_WATER   = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frame_start,
    input  logic              pix_rd,
    output logic [DATA_W-1:0] pix_data,
    output logic              pix_valid,
    output logic              underrun,
    input  logic              wr_valid,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output fb_state_e         dbg_state
);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = LVL_W + 1;
    localparam logic [OCC_W-1:0]  DEPTH_OCC = OCC_W'(FIFO_DEPTH);
    localparam logic [OCC_W-1:0]  LOW_OCC   = OCC_W'(LOW_WATER);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_WORDS - 1);

    fb_state_e         state_q, state_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic              ret_q, ret_d;        // tracked read data on mem_rdata now
    logic              mem_re_q, mem_re_d;  // tracked read strobed to RAM now
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              underrun_q, underrun_d;

    logic [LVL_W-1:0]  level;
    logic [OCC_W-1:0]  occ;
    logic              rd_grant, wr_grant;
    logic              flush, fifo_empty, push, pop;

    // Slot choice: scanout below low water beats the writer, otherwise writer first.
    always_comb begin
        occ      = {1'b0, level} + OCC_W'(mem_re_q) + OCC_W'(ret_q);
        rd_grant = (state_q == ST_RUN) && (occ < DEPTH_OCC)
                   && ((occ < LOW_OCC) || !wr_valid);
        wr_grant = wr_valid && !rd_grant && !rst;
    end

    // Next-state, read pointer, read tracking and registered RAM port.
    always_comb begin
        flush       = (state_q == ST_FLUSH);
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        case (state_q)
            ST_FLUSH: begin
                state_d  = ST_RUN;
                rd_ptr_d = '0;
            end
            ST_RUN: begin
                if (rd_grant) begin
                    if (rd_ptr_q == LAST_ADDR) begin
                        state_d = ST_DONE;
                    end else begin
                        rd_ptr_d = rd_ptr_q + 1'b1;
                    end
                end
            end
            default: state_d = state_q;
        endcase
        if (frame_start) begin
            state_d = ST_FLUSH;
        end

        // Reads in flight across a flush are stale: drop their tracking so
        // the RAM return is ignored and never reaches the FIFO.
        mem_re_d    = rd_grant;
        ret_d       = mem_re_q && !flush;
        push        = ret_q && !flush;
        pop         = pix_rd && !fifo_empty;

        mem_we_d    = wr_grant;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if (rd_grant) begin
            mem_addr_d = rd_ptr_q;
        end else if (wr_grant) begin
            mem_addr_d  = wr_addr;
            mem_wdata_d = wr_data;
        end

        underrun_d = flush ? 1'b0 : (underrun_q || (pix_rd && fifo_empty));
    end

    // Single state/output register bank.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_FLUSH;
            rd_ptr_q    <= '0;
            ret_q       <= 1'b0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            ret_q       <= ret_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            underrun_q  <= underrun_d;
        end
    end

    vga_pix_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .clr       (flush),
        .push      (push),
        .push_data (mem_rdata),
        .pop       (pop),
        .head      (pix_data),
        .empty     (fifo_empty),
        .level     (level)
    );

    // Output mapping.
    always_comb begin
        pix_valid = !fifo_empty;
        underrun  = underrun_q;
        wr_ready  = wr_grant;
        mem_addr  = mem_addr_q;
        mem_re    = mem_re_q;
        mem_we    = mem_we_q;
        mem_wdata = mem_wdata_q;
        dbg_state = state_q;
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Directed bench for vga_fb_arbiter with a small frame and a synchronous RAM model.
module tb_vga_fb_arbiter;
  import vga_fb_pkg::*;

  localparam int TB_FRAME = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              frame_start = 1'b0;
  logic              pix_rd = 1'b0;
  logic [DATA_W-1:0] pix_data;
  logic              pix_valid;
  logic              underrun;
  logic              wr_valid = 1'b0;
  logic [ADDR_W-1:0] wr_addr = '0;
  logic [DATA_W-1:0] wr_data = '0;
  logic              wr_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_re;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  fb_state_e         dbg_state;

  int checks = 0;
  int failures = 0;

  logic [DATA_W-1:0] ram [128];

  vga_fb_arbiter #(
    .FRAME_WORDS (TB_FRAME),
    .FIFO_DEPTH  (16),
    .LOW_WATER   (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .frame_start (frame_start),
    .pix_rd      (pix_rd),
    .pix_data    (pix_data),
    .pix_valid   (pix_valid),
    .underrun    (underrun),
    .wr_valid    (wr_valid),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .wr_ready    (wr_ready),
    .mem_addr    (mem_addr),
    .mem_re      (mem_re),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .dbg_state   (dbg_state)
  );

  // clock / reset block
  always #5 clk = ~clk;

  // synchronous single-port RAM, preloaded with ram[i] = i while in reset
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 128; i++) ram[i] <= DATA_W'(i);
      mem_rdata <= '0;
    end else begin
      if (mem_we) ram[mem_addr[6:0]] <= mem_wdata;
      if (mem_re) mem_rdata <= ram[mem_addr[6:0]];
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // expected scanout word: address 60 is overwritten by the writer mid-frame
  function automatic logic [31:0] exp_pix(input int a);
    return (a == 60) ? 32'h00ABCDEF : 32'(a);
  endfunction

  initial begin
    // ---- reset values
    repeat (2) @(posedge clk);
    #1;
    check("rst_pix_valid", 32'(pix_valid), 0);
    check("rst_pix_data", 32'(pix_data), 0);
    check("rst_underrun", 32'(underrun), 0);
    check("rst_wr_ready", 32'(wr_ready), 0);
    check("rst_mem_re", 32'(mem_re), 0);
    check("rst_mem_we", 32'(mem_we), 0);
    check("rst_mem_addr", 32'(mem_addr), 0);
    check("rst_mem_wdata", 32'(mem_wdata), 0);
    check("rst_state", 32'(dbg_state), 32'(ST_FLUSH));
    rst = 1'b0;

    // ---- fill with idle writer: grants in cycles 1..16
    tick();  // cycle 1
    check("c1_state", 32'(dbg_state), 32'(ST_RUN));
    check("c1_mem_re", 32'(mem_re), 0);
    tick();  // cycle 2
    check("c2_mem_re", 32'(mem_re), 1);
    check("c2_mem_addr", 32'(mem_addr), 0);
    tick();  // cycle 3
    check("c3_pix_valid", 32'(pix_valid), 0);
    check("c3_mem_addr", 32'(mem_addr), 1);
    tick();  // cycle 4: pix_valid three cycles after first grant
    check("c4_pix_valid", 32'(pix_valid), 1);
    check("c4_pix_data", 32'(pix_data), 0);
    for (int c = 5; c <= 17; c++) begin
      tick();
      check("fill_mem_re", 32'(mem_re), 1);
      check("fill_mem_addr", 32'(mem_addr), 32'(c - 2));
    end
    for (int c = 18; c <= 22; c++) begin
      tick();
      check("full_mem_re", 32'(mem_re), 0);
    end

    // ---- continuous pops: 0..39 with no gaps
    for (int k = 0; k < 40; k++) begin
      pix_rd = 1'b1;
      #1;
      check("stream_valid", 32'(pix_valid), 1);
      check("stream_data", 32'(pix_data), exp_pix(k));
      tick();
    end
    pix_rd = 1'b0;
    repeat (6) tick();
    check("stream_underrun", 32'(underrun), 0);
    check("refill_mem_re", 32'(mem_re), 0);

    // ---- writer busy above low water
    wr_valid = 1'b1;
    wr_addr  = ADDR_W'(60);
    wr_data  = 24'hABCDEF;
    #1;
    check("wr_full_ready", 32'(wr_ready), 1);
    tick();
    check("wr_mem_we", 32'(mem_we), 1);
    check("wr_mem_addr", 32'(mem_addr), 60);
    check("wr_mem_wdata", 32'(mem_wdata), 32'h00ABCDEF);
    wr_addr = ADDR_W'(100);
    wr_data = 24'h123456;
    for (int k = 0; k < 6; k++) begin
      pix_rd = 1'b1;
      #1;
      check("busy_pop_data", 32'(pix_data), exp_pix(40 + k));
      check("busy_wr_ready", 32'(wr_ready), 1);
      check("busy_mem_re", 32'(mem_re), 0);
      tick();
    end
    pix_rd = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("lvl10_wr_ready", 32'(wr_ready), 1);
      check("lvl10_mem_re", 32'(mem_re), 0);
      tick();
    end
    for (int k = 0; k < 7; k++) begin
      pix_rd = 1'b1;
      #1;
      check("drain_pop_data", 32'(pix_data), exp_pix(46 + k));
      check("drain_wr_ready", 32'(wr_ready), 1);
      tick();
    end
    pix_rd = 1'b0;
    #1;
    check("occ3_wr_ready", 32'(wr_ready), 0);
    tick();
    check("occ3_mem_re", 32'(mem_re), 1);
    check("occ3_mem_addr", 32'(mem_addr), 56);
    check("occ4_wr_ready", 32'(wr_ready), 1);
    tick();
    check("occ4_mem_re", 32'(mem_re), 0);
    check("occ4_mem_we", 32'(mem_we), 1);
    check("occ4_mem_addr", 32'(mem_addr), 100);

    // ---- finish the frame: reads 57..63 then DONE
    wr_valid = 1'b0;
    repeat (14) tick();
    check("done_state", 32'(dbg_state), 32'(ST_DONE));
    wr_valid = 1'b1;
    wr_addr  = ADDR_W'(101);
    for (int k = 0; k < 4; k++) begin
      #1;
      check("done_wr_ready", 32'(wr_ready), 1);
      check("done_mem_re", 32'(mem_re), 0);
      tick();
    end
    wr_valid = 1'b0;
    for (int k = 53; k < 64; k++) begin
      pix_rd = 1'b1;
      #1;
      check("tail_valid", 32'(pix_valid), 1);
      check("tail_data", 32'(pix_data), exp_pix(k));
      tick();
    end
    pix_rd = 1'b0;
    #1;
    check("empty_valid", 32'(pix_valid), 0);
    check("empty_hold_data", 32'(pix_data), 63);
    check("empty_underrun_pre", 32'(underrun), 0);

    // ---- underrun on empty pop, sticky
    pix_rd = 1'b1;
    tick();
    pix_rd = 1'b0;
    check("underrun_set", 32'(underrun), 1);
    check("underrun_hold_data", 32'(pix_data), 63);
    repeat (3) tick();
    check("underrun_sticky", 32'(underrun), 1);

    // ---- frame_start from DONE, then again with two reads in flight
    frame_start = 1'b1;
    tick();  // FLUSH
    frame_start = 1'b0;
    check("fs1_state", 32'(dbg_state), 32'(ST_FLUSH));
    check("fs1_underrun", 32'(underrun), 1);
    tick();  // R1: grant addr 0
    check("fs1_run", 32'(dbg_state), 32'(ST_RUN));
    check("fs1_underrun_clr", 32'(underrun), 0);
    check("fs1_pix_valid", 32'(pix_valid), 0);
    tick();  // R2: grant addr 1, frame_start
    check("r2_mem_addr", 32'(mem_addr), 0);
    frame_start = 1'b1;
    tick();  // R3: FLUSH with two reads in flight
    frame_start = 1'b0;
    check("fs2_state", 32'(dbg_state), 32'(ST_FLUSH));
    check("fs2_mem_re", 32'(mem_re), 1);
    check("fs2_mem_addr", 32'(mem_addr), 1);
    tick();  // R4
    check("r4_mem_re", 32'(mem_re), 0);
    check("r4_pix_valid", 32'(pix_valid), 0);
    tick();  // R5
    check("r5_mem_re", 32'(mem_re), 1);
    check("r5_mem_addr", 32'(mem_addr), 0);
    check("r5_pix_valid", 32'(pix_valid), 0);
    tick();  // R6
    check("r6_pix_valid", 32'(pix_valid), 0);
    check("r6_mem_addr", 32'(mem_addr), 1);
    tick();  // R7
    check("r7_pix_valid", 32'(pix_valid), 1);
    check("r7_pix_data", 32'(pix_data), 0);
    check("r7_mem_addr", 32'(mem_addr), 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
